// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code parameters, FSM states and soft-symbol type shared by encoder and decoder
package viterbi_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int SYM_W = 8;
  typedef enum logic {DATA, TAIL} state_t;
  typedef logic signed [SYM_W-1:0] sym_t;
endpackage

// File: rtl/conv_encoder_if.sv
// conv_encoder_if: input-bit and output-symbol-pair valid/ready handshakes of the encoder
interface conv_encoder_if #(parameter int W = 8);
  logic in_bit, in_last, in_valid, in_ready;
  logic signed [W-1:0] sym0, sym1;
  logic out_last, out_valid, out_ready;
  modport master (
    output in_bit, in_last, in_valid, out_ready,
    input  in_ready, sym0, sym1, out_last, out_valid
  );
  modport slave (
    input  in_bit, in_last, in_valid, out_ready,
    output in_ready, sym0, sym1, out_last, out_valid
  );
endinterface

// File: rtl/bpsk_map.sv
// bpsk_map: antipodal mapping of a coded bit to a signed symbol, 0 -> +AMP, 1 -> -AMP
module bpsk_map #(parameter int W = 8, parameter int AMP = 2) (
  input  logic                b,
  output logic signed [W-1:0] s
);
  localparam logic signed [W-1:0] A = W'(AMP);
  assign s = b ? -A : A;
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 (7,5) encoder emitting +-AMP soft pairs; CONV_ENC_TAIL_EN adds zero-tail frame termination
module conv_encoder
  import viterbi_pkg::*;
#(parameter int W = 8, parameter int AMP = 2) (
  input logic clk,
  input logic reset,
  conv_encoder_if.slave bus
);
  logic [1:0] sr;
  logic slot, u, c0, c1, produce, last;
  logic signed [W-1:0] s0, s1;
  assign slot = !bus.out_valid || bus.out_ready;
`ifdef CONV_ENC_TAIL_EN
  state_t state;
  logic tcnt;
  assign bus.in_ready = !reset && state == DATA && slot;
  assign u = state == DATA && bus.in_bit;
  assign produce = state == TAIL ? slot : bus.in_valid && bus.in_ready;
  assign last = state == TAIL && tcnt;
`else
  assign bus.in_ready = !reset && slot;
  assign u = bus.in_bit;
  assign produce = bus.in_valid && bus.in_ready;
  assign last = bus.in_last;
`endif
  // tap vector ordered newest-first so the generator constants read as written
  assign c0 = ^({u, sr[0], sr[1]} & G0);
  assign c1 = ^({u, sr[0], sr[1]} & G1);
  bpsk_map #(.W(W), .AMP(AMP)) map0 (.b(c0), .s(s0));
  bpsk_map #(.W(W), .AMP(AMP)) map1 (.b(c1), .s(s1));
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.sym0 <= '0;
      bus.sym1 <= '0;
      sr <= '0;
`ifdef CONV_ENC_TAIL_EN
      state <= DATA;
      tcnt <= 1'b0;
`endif
    end else begin
      if (produce) begin
        bus.sym0 <= s0;
        bus.sym1 <= s1;
        bus.out_last <= last;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      if (produce && state == DATA) begin
        sr <= {sr[0], u};
        if (bus.in_last) state <= TAIL;
      end else if (produce) begin
        sr <= tcnt ? 2'b00 : {sr[0], 1'b0};
        tcnt <= !tcnt;
        if (tcnt) state <= DATA;
      end
`else
      if (produce) sr <= bus.in_last ? 2'b00 : {sr[0], u};
`endif
    end
  end
endmodule
